mips_datapath_alu_hilo: RTL and testbench
=========================================

Name: mips_datapath_alu_hilo

Overview:
HI/LO special-register unit downstream of the EX-stage ALU.
- Captures the ALU's res_lo/res_hi for mult/mthi/mtlo.
- Feeds reg_lo/reg_hi back to the ALU for mflo/mfhi.
- Hosts the multi-cycle radix-2 restoring divider for div/divu, which the ALU does not implement.
- Asserts busy to stall the pipeline while a divide is in flight.

Parameters:
DATA_W, 32, datapath width; also the number of divider iterations.

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset_n  input  1  synchronous, active-low reset
valid  input  1  EX-stage instruction is live (not a bubble)
flush  input  1  kill the EX instruction and abort any divide in flight
func  input  Func_T  ALU function code from the shared ALU Func encoding
data1  input  DATA_W  rs operand; the dividend
data2  input  DATA_W  rt operand; the divisor
res_lo  input  DATA_W  ALU low result
res_hi  input  DATA_W  ALU high result
reg_lo  output  DATA_W  current LO register value
reg_hi  output  DATA_W  current HI register value
busy  output  1  divider occupied; upstream must hold EX

Behaviour:
- Reset (reset_n=0 at an edge):
  - reg_lo=0, reg_hi=0, busy=0, FSM=IDLE.
  - Reset in the middle of a divide aborts it; HI/LO are cleared.
- Accept condition: valid & ~busy & ~flush. When accepted:
  - Muls/Mulu: LO<=res_lo, HI<=res_hi.
  - Mtlo: LO<=res_lo. Mthi: HI<=res_hi.
  - Divs/Divu: start the divider; HI/LO are unchanged until completion.
  - Any other func: no effect.
- Writes become visible on reg_lo/reg_hi the cycle after the edge. There is no same-cycle bypass.
- While busy=1, valid/func are ignored; the stall is the hazard unit's responsibility.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on a div accept. In the same edge:
    - latch |data1| and |data2| (Divs) or raw values (Divu);
    - record sign_q = s1^s2 and sign_r = s1;
    - cnt <= DATA_W; partial remainder (DATA_W+1 bits) <= 0.
  - RUN: each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor.
    - Non-negative trial: keep it, quotient bit = 1.
    - Negative trial: restore, quotient bit = 0.
    - Decrement cnt. When cnt reaches 1, next state is FIX.
  - FIX (one cycle):
    - LO <= sign_q ? -quo : quo.
    - HI <= sign_r ? -rem : rem.
    - Next state IDLE.
- busy = (state != IDLE), a registered decode. A div accepted at edge N holds busy high for edges N+1 .. N+DATA_W+1 (33 cycles at DATA_W=32). Results are visible on the cycle busy drops.
- Divide by zero (data2==0): LO=all ones, HI=data1, for both Divs and Divu, selected in FIX.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. This falls out of the magnitude arithmetic and needs no special case.
- Flush:
  - Any state -> IDLE next edge; HI/LO are untouched and busy drops.
  - flush together with an accept: flush wins; nothing is written or started.
- Remainder sign always follows the dividend; |HI| < |divisor| whenever the divisor is nonzero.

Optional Feature:
MIPS_DATAPATH_ALU_HILO_EARLY_EXIT_EN
- Defined: on a div accept where data2==0 or |data1|<|data2| (unsigned compare for Divu), go IDLE -> FIX directly.
  - Results: quo=0, rem=dividend magnitude; divide-by-zero rule still applies.
  - busy is high for exactly 1 cycle.
- Undefined: every divide takes the full DATA_W+1 busy cycles.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/RUN/FIX) and its width;
  - divider iteration-counter width, log2(DATA_W)+1;
  - reuse the existing ALU Func codes, adding Divs/Divu codes there.
- Sub-module: mips_datapath_alu_divider, the iterative unsigned core.
  - Signals: start, operands, done, quo, rem.
  - Sign handling, HI/LO registers and decode stay in the top module.

Test Plan:
- Reset, then Mulu with res_lo=0x12345678, res_hi=0x9 -> next cycle reg_lo=0x12345678, reg_hi=0x9, busy=0.
- Mtlo res_lo=0xA followed by Mthi res_hi=0xB on back-to-back cycles -> LO=0xA, HI=0xB; neither write clobbers the other register.
- Divs data1=-7 (0xFFFFFFF9), data2=2 -> busy high 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divu with the same operands -> LO=0x7FFFFFFC, HI=1.
- Divu data2=0, data1=0x55 -> LO=0xFFFFFFFF, HI=0x55. Divs 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start Divu 100/7 with prior LO=0x1, HI=0x2:
  - Assert flush at busy cycle 10 -> busy=0 next cycle, LO=0x1, HI=0x2 unchanged.
  - Mult issued with valid during busy -> ignored.
- Reset_n=0 mid-divide -> LO=HI=0, busy=0. With EARLY_EXIT_EN, Divu 3/10 -> busy 1 cycle, LO=0, HI=3.

Source files
------------

// File: rtl/mips_datapath_alu_hilo_pkg.sv
// Shared definitions for the HI/LO unit: ALU function codes, divider FSM state
// and the iteration-counter width helper.
package mips_datapath_alu_hilo_pkg;

  localparam int HILO_DATA_W = 32;

  typedef enum logic [4:0] {
    Add  = 5'd0,  Addu = 5'd1,  Sub  = 5'd2,  Subu = 5'd3,
    And  = 5'd4,  Or   = 5'd5,  Xor  = 5'd6,  Nor  = 5'd7,
    Slt  = 5'd8,  Sltu = 5'd9,  Sll  = 5'd10, Srl  = 5'd11,
    Sra  = 5'd12, Lui  = 5'd13, Muls = 5'd14, Mulu = 5'd15,
    Mflo = 5'd16, Mfhi = 5'd17, Mtlo = 5'd18, Mthi = 5'd19,
    Divs = 5'd20, Divu = 5'd21
  } Func_T;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Counter must hold DATA_W itself, hence one bit beyond log2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mips_datapath_alu_hilo_if.sv
// EX-stage to HI/LO unit bus: instruction/operand side in, HI/LO and stall out.
interface mips_datapath_alu_hilo_if
  import mips_datapath_alu_hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) ();

  logic              valid;
  logic              flush;
  Func_T             func;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] res_lo;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] reg_lo;
  logic [DATA_W-1:0] reg_hi;
  logic              busy;

  modport master (
    output valid, flush, func, data1, data2, res_lo, res_hi,
    input  reg_lo, reg_hi, busy
  );

  modport slave (
    input  valid, flush, func, data1, data2, res_lo, res_hi,
    output reg_lo, reg_hi, busy
  );

endinterface

// File: rtl/mips_datapath_alu_divider.sv
// Iterative radix-2 restoring unsigned divider; one quotient bit per RUN cycle,
// results held while in FIX (done=1). abort returns to IDLE from any state.
module mips_datapath_alu_divider
  import mips_datapath_alu_hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              early,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem
);

  localparam int CNT_W = cnt_width(DATA_W);

  div_state_t        state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] rem_r, quo_r, dvs_r;
  logic [DATA_W-1:0] rem_nx, quo_nx;
  logic [DATA_W:0]   shift_s, trial_s;
  logic              busy_r;

  // Shift/trial-subtract step; the remainder always fits DATA_W bits after it.
  always_comb begin
    shift_s = {rem_r, quo_r[DATA_W-1]};
    trial_s = shift_s - {1'b0, dvs_r};
    if (trial_s[DATA_W]) begin
      rem_nx = shift_s[DATA_W-1:0];
      quo_nx = {quo_r[DATA_W-2:0], 1'b0};
    end else begin
      rem_nx = trial_s[DATA_W-1:0];
      quo_nx = {quo_r[DATA_W-2:0], 1'b1};
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nx = start ? (early ? FIX : RUN) : IDLE;
        RUN:     state_nx = (cnt_r == CNT_W'(1)) ? FIX : RUN;
        FIX:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath registers and registered busy decode.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nx != IDLE);
      if (state_r == IDLE && start && !abort) begin
        dvs_r <= divisor;
        cnt_r <= CNT_W'(DATA_W);
        rem_r <= early ? dividend : '0;
        quo_r <= early ? '0 : dividend;
      end else if (state_r == RUN) begin
        rem_r <= rem_nx;
        quo_r <= quo_nx;
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

  assign done = (state_r == FIX);
  assign busy = busy_r;
  assign quo  = quo_r;
  assign rem  = rem_r;

endmodule

// File: rtl/mips_datapath_alu_hilo.sv
// HI/LO register unit with multi-cycle div/divu.
// Optional MIPS_DATAPATH_ALU_HILO_EARLY_EXIT_EN skips iterations when the quotient is zero.
module mips_datapath_alu_hilo
  import mips_datapath_alu_hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) (
  input logic                     clock,
  input logic                     reset_n,
  mips_datapath_alu_hilo_if.slave hilo
);

  logic              accept_s, is_div_s, is_signed_s, start_s, early_s;
  logic              done_s, busy_s;
  logic [DATA_W-1:0] mag1_s, mag2_s, quo_s, rem_s;
  logic [DATA_W-1:0] lo_r, hi_r;
  logic              sign_q_r, sign_rem_r, div0_r;

  // Accept decode and operand magnitudes.
  always_comb begin
    accept_s    = hilo.valid & ~busy_s & ~hilo.flush;
    is_div_s    = (hilo.func == Divs) || (hilo.func == Divu);
    is_signed_s = (hilo.func == Divs);
    start_s     = accept_s & is_div_s;
    mag1_s      = (is_signed_s && hilo.data1[DATA_W-1]) ? -hilo.data1 : hilo.data1;
    mag2_s      = (is_signed_s && hilo.data2[DATA_W-1]) ? -hilo.data2 : hilo.data2;
`ifdef MIPS_DATAPATH_ALU_HILO_EARLY_EXIT_EN
    early_s     = (mag2_s == '0) || (mag1_s < mag2_s);
`else
    early_s     = 1'b0;
`endif
  end

  mips_datapath_alu_divider #(.DATA_W(DATA_W)) u_divider (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start_s),
    .abort    (hilo.flush),
    .early    (early_s),
    .dividend (mag1_s),
    .divisor  (mag2_s),
    .done     (done_s),
    .busy     (busy_s),
    .quo      (quo_s),
    .rem      (rem_s)
  );

  // HI/LO writes; divide results are sign-corrected here, div-by-zero forces LO to ones.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lo_r       <= '0;
      hi_r       <= '0;
      sign_q_r   <= 1'b0;
      sign_rem_r <= 1'b0;
      div0_r     <= 1'b0;
    end else if (done_s && !hilo.flush) begin
      lo_r <= div0_r ? '1 : (sign_q_r ? -quo_s : quo_s);
      hi_r <= sign_rem_r ? -rem_s : rem_s;
    end else if (accept_s) begin
      case (hilo.func)
        Muls, Mulu: begin
          lo_r <= hilo.res_lo;
          hi_r <= hilo.res_hi;
        end
        Mtlo: lo_r <= hilo.res_lo;
        Mthi: hi_r <= hilo.res_hi;
        Divs: begin
          sign_q_r   <= hilo.data1[DATA_W-1] ^ hilo.data2[DATA_W-1];
          sign_rem_r <= hilo.data1[DATA_W-1];
          div0_r     <= (hilo.data2 == '0);
        end
        Divu: begin
          sign_q_r   <= 1'b0;
          sign_rem_r <= 1'b0;
          div0_r     <= (hilo.data2 == '0);
        end
        default: begin
        end
      endcase
    end
  end

  assign hilo.reg_lo = lo_r;
  assign hilo.reg_hi = hi_r;
  assign hilo.busy   = busy_s;

endmodule

// File: tb/tb_mips_datapath_alu_hilo.sv
// Directed bench for mips_datapath_alu_hilo: mult/mt writes, divides, flush and reset.
module tb_mips_datapath_alu_hilo;
  import mips_datapath_alu_hilo_pkg::*;

`ifdef MIPS_DATAPATH_ALU_HILO_EARLY_EXIT_EN
  localparam int EARLY_CYC = 1;
`else
  localparam int EARLY_CYC = 33;
`endif

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  mips_datapath_alu_hilo_if #(.DATA_W(32)) hilo_bus ();

  mips_datapath_alu_hilo #(.DATA_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .hilo    (hilo_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input Func_T f, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] lo, input logic [31:0] hi);
    hilo_bus.valid  = 1'b1;
    hilo_bus.func   = f;
    hilo_bus.data1  = d1;
    hilo_bus.data2  = d2;
    hilo_bus.res_lo = lo;
    hilo_bus.res_hi = hi;
    step();
    hilo_bus.valid  = 1'b0;
  endtask

  task automatic run_div(input string tag, input Func_T f, input logic [31:0] d1,
                         input logic [31:0] d2, input int exp_cyc,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    issue(f, d1, d2, 32'h0000_0000, 32'h0000_0000);
    n = 0;
    while (hilo_bus.busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    check_eq({tag, "_cycles"}, n, exp_cyc);
    check_eq({tag, "_lo"}, hilo_bus.reg_lo, exp_lo);
    check_eq({tag, "_hi"}, hilo_bus.reg_hi, exp_hi);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    hilo_bus.valid  = 1'b0;
    hilo_bus.flush  = 1'b0;
    hilo_bus.func   = Add;
    hilo_bus.data1  = 32'h0000_0000;
    hilo_bus.data2  = 32'h0000_0000;
    hilo_bus.res_lo = 32'h0000_0000;
    hilo_bus.res_hi = 32'h0000_0000;
    step();
    step();
    check_eq("rst_lo", hilo_bus.reg_lo, 32'h0000_0000);
    check_eq("rst_hi", hilo_bus.reg_hi, 32'h0000_0000);
    check_eq("rst_busy", {31'd0, hilo_bus.busy}, 32'd0);
    reset_n = 1'b1;
    step();

    issue(Mulu, 32'h0, 32'h0, 32'h1234_5678, 32'h0000_0009);
    check_eq("mulu_lo", hilo_bus.reg_lo, 32'h1234_5678);
    check_eq("mulu_hi", hilo_bus.reg_hi, 32'h0000_0009);
    check_eq("mulu_busy", {31'd0, hilo_bus.busy}, 32'd0);

    issue(Add, 32'h0, 32'h0, 32'hFFFF_0000, 32'h0000_FFFF);
    check_eq("add_noeffect_lo", hilo_bus.reg_lo, 32'h1234_5678);
    check_eq("add_noeffect_hi", hilo_bus.reg_hi, 32'h0000_0009);

    issue(Muls, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    check_eq("muls_lo", hilo_bus.reg_lo, 32'hFFFF_FFFE);
    check_eq("muls_hi", hilo_bus.reg_hi, 32'hFFFF_FFFF);

    issue(Mtlo, 32'h0, 32'h0, 32'h0000_000A, 32'h0000_DEAD);
    issue(Mthi, 32'h0, 32'h0, 32'h0000_BEEF, 32'h0000_000B);
    check_eq("mt_lo", hilo_bus.reg_lo, 32'h0000_000A);
    check_eq("mt_hi", hilo_bus.reg_hi, 32'h0000_000B);

    run_div("divs_m7_2", Divs, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu_m7_2", Divu, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'h7FFF_FFFC, 32'h0000_0001);
    run_div("divs_7_m2", Divs, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'h0000_0001);
    run_div("divu_by0", Divu, 32'h0000_0055, 32'h0000_0000, EARLY_CYC, 32'hFFFF_FFFF, 32'h0000_0055);
    run_div("divs_by0", Divs, 32'hFFFF_FFF9, 32'h0000_0000, EARLY_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_div("divs_ovf", Divs, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0000_0000);
    run_div("divu_3_10", Divu, 32'h0000_0003, 32'h0000_000A, EARLY_CYC, 32'h0000_0000, 32'h0000_0003);
    run_div("divu_100_7", Divu, 32'd100, 32'd7, 33, 32'd14, 32'd2);

    // Flush mid-divide, with a mult issued while busy.
    issue(Mtlo, 32'h0, 32'h0, 32'h0000_0001, 32'h0);
    issue(Mthi, 32'h0, 32'h0, 32'h0, 32'h0000_0002);
    issue(Divu, 32'd100, 32'd7, 32'h0, 32'h0);
    check_eq("flush_busy_start", {31'd0, hilo_bus.busy}, 32'd1);
    step();
    issue(Mulu, 32'h0, 32'h0, 32'h0000_0BAD, 32'h0000_0BAD);
    check_eq("busy_mult_ignored_lo", hilo_bus.reg_lo, 32'h0000_0001);
    for (int i = 0; i < 6; i++) step();
    check_eq("flush_busy_before", {31'd0, hilo_bus.busy}, 32'd1);
    hilo_bus.flush = 1'b1;
    step();
    hilo_bus.flush = 1'b0;
    check_eq("flush_busy", {31'd0, hilo_bus.busy}, 32'd0);
    check_eq("flush_lo", hilo_bus.reg_lo, 32'h0000_0001);
    check_eq("flush_hi", hilo_bus.reg_hi, 32'h0000_0002);
    for (int i = 0; i < 40; i++) step();
    check_eq("flush_lo_later", hilo_bus.reg_lo, 32'h0000_0001);

    // Flush together with an accept: nothing written or started.
    hilo_bus.flush = 1'b1;
    issue(Mtlo, 32'h0, 32'h0, 32'h0000_0077, 32'h0);
    check_eq("flush_acc_lo", hilo_bus.reg_lo, 32'h0000_0001);
    issue(Divu, 32'd100, 32'd7, 32'h0, 32'h0);
    hilo_bus.flush = 1'b0;
    check_eq("flush_acc_busy", {31'd0, hilo_bus.busy}, 32'd0);
    step();
    check_eq("flush_acc_busy2", {31'd0, hilo_bus.busy}, 32'd0);

    // Reset in the middle of a divide.
    run_div("divu_pre_rst", Divu, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    issue(Divu, 32'd100, 32'd7, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    reset_n = 1'b0;
    step();
    check_eq("midrst_lo", hilo_bus.reg_lo, 32'h0000_0000);
    check_eq("midrst_hi", hilo_bus.reg_hi, 32'h0000_0000);
    check_eq("midrst_busy", {31'd0, hilo_bus.busy}, 32'd0);
    reset_n = 1'b1;
    step();
    check_eq("postrst_busy", {31'd0, hilo_bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
